ps2_keyboard_rx: RTL
====================

// Module: ps2_keyboard_rx
// PURPOSE
//   Receives PS/2 keyboard frames, decodes make/break/extended prefixes and queues
//   key events in a FIFO the CPU pops through its memory-mapped port. Input-side
//   counterpart of the VGA character output path: CPU reads key events here and
//   writes the resulting characters into charArray. Runs on the system clk.
// PARAMETERS
//   FIFO_DEPTH      8      key-event entries; power of 2, >= 2
//   TIMEOUT_CYCLES  12500  clk cycles with no ps2_clk falling edge that abort a partial frame
// PORTS
//   clk         in   1    system clock
//   rst         in   1    synchronous reset, active high
//   ps2_clk     in   1    PS/2 clock from keyboard, asynchronous
//   ps2_data    in   1    PS/2 data from keyboard, asynchronous
//   rd_en       in   1    pop head entry (CPU read strobe), one pop per high cycle
//   rd_data     out  10   head entry {ext, brk, code[7:0]}; valid when empty=0
//   empty       out  1    FIFO holds no entries
//   full        out  1    FIFO holds FIFO_DEPTH entries
//   count       out  $clog2(FIFO_DEPTH)+1  entries held
//   overflow    out  1    sticky: event dropped because FIFO full
//   ovf_clr     in   1    clears overflow
//   parity_err  out  1    one-cycle pulse: frame rejected (parity or stop bit bad)
// BEHAVIOUR
//   Reset: FSM->IDLE, bit counter, timeout counter, ext/brk flags, FIFO pointers cleared;
//     empty=1, full=0, count=0, overflow=0, parity_err=0, rd_data=0. Reset mid-frame
//     discards the partial frame and all queued entries.
//   Input sync: ps2_clk, ps2_data each through 2 flops; falling edge = prev synced 1,
//     current synced 0. Data is sampled from synced ps2_data on the edge-detect cycle.
//   Frame: start(0), 8 data bits LSB first, odd parity, stop(1).
//   FSM states/transitions (advance only on falling edges):
//     IDLE   : data=0 -> DATA, bit_cnt=0; data=1 -> stay (glitch ignored)
//     DATA   : shift bit in; after 8th bit -> PARITY
//     PARITY : latch parity bit -> STOP
//     STOP   : ok = (^code ^ parity)==1 && data==1; ok -> frame_valid pulse next cycle;
//              not ok -> parity_err pulse next cycle, clear ext/brk; -> IDLE
//   Timeout: in any state but IDLE, counter increments each clk, resets on every falling
//     edge; reaching TIMEOUT_CYCLES -> IDLE, partial frame discarded, no error pulse.
//   Decode on frame_valid: code E0 -> ext=1, no push; F0 -> brk=1, no push; any other
//     code -> push {ext,brk,code}, then ext=brk=0.
//   Latency: stop edge detected cycle N; frame_valid at N+1; entry written and empty=0,
//     count updated, rd_data valid at N+2.
//   FIFO: first-word fall-through; rd_data = mem[rd_ptr] combinationally. Pointers wrap
//     modulo FIFO_DEPTH; count is registered.
//     rd_en while empty: ignored, no pointer move.
//     push while full with no pop: entry dropped, overflow set next cycle.
//     push and rd_en same cycle: both performed, count unchanged (also when full or empty
//       -- empty case: push only, rd_en ignored).
//     ovf_clr and new overflow same cycle: overflow stays 1 (set wins).
// TESTING
//   1 frame 0x1C, parity 0, stop 1 -> rd_data=10'h01C, count=1 two cycles after stop edge
//   2 frames F0,1C -> exactly one entry 10'h11C; F0 alone leaves FIFO empty
//   3 frames E0,F0,75 -> one entry 10'h375; following 0x29 -> 10'h029 (flags cleared)
//   4 frame 0x1C with parity 1 -> parity_err one cycle, count=0; next valid 0x1C -> 10'h01C
//   5 nine make codes 0x16..0x1E, no reads -> full=1, count=8, overflow=1, head=10'h016;
//     pop+push same cycle keeps count=8; ovf_clr -> overflow=0
//   6 stop ps2_clk after 4 data bits, wait TIMEOUT_CYCLES+2 -> FSM IDLE, no entry, no
//     parity_err; next frame 0x29 -> 10'h029; assert rst mid-frame -> empty=1, count=0

Source files
------------

// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver: synchronises the PS/2 lines, deframes start/data/parity/stop,
// folds E0/F0 prefixes into flags and queues {ext,brk,code} events in a fall-through FIFO.
module ps2_keyboard_rx #(
  parameter int FIFO_DEPTH     = 8,
  parameter int TIMEOUT_CYCLES = 12500
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          ps2_clk,
  input  logic                          ps2_data,
  input  logic                          rd_en,
  output logic [9:0]                    rd_data,
  output logic                          empty,
  output logic                          full,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          overflow,
  input  logic                          ovf_clr,
  output logic                          parity_err
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  // Odd parity over code plus parity bit, and a high stop bit, make a good frame.
  function automatic logic frame_ok(input logic [7:0] code, input logic par, input logic stop);
    return ((^code) ^ par) && stop;
  endfunction

  function automatic logic is_prefix(input logic [7:0] code);
    return (code == 8'hE0) || (code == 8'hF0);
  endfunction

  state_t            state;
  logic [2:0]        bit_cnt;
  logic [TW-1:0]     tmo_cnt;
  logic              ps2c_p0, ps2c_p1, ps2c_p2;
  logic              ps2d_p0, ps2d_p1;
  logic              fall;
  logic              bit_in;
  logic [7:0]        code_p0;
  logic              par_p0;
  logic [7:0]        code_p1;
  logic              vld_p1;
  logic              ext, brk;
  logic              push, do_push, do_pop;
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [9:0]        mem [FIFO_DEPTH];

  // Stage p0/p1: two-flop synchronisers; p2 holds the previous synced clock for edge detect.
  always_ff @(posedge clk) begin
    if (rst) begin
      ps2c_p0 <= 1'b1;
      ps2c_p1 <= 1'b1;
      ps2c_p2 <= 1'b1;
      ps2d_p0 <= 1'b1;
      ps2d_p1 <= 1'b1;
    end else begin
      ps2c_p0 <= ps2_clk;
      ps2c_p1 <= ps2c_p0;
      ps2c_p2 <= ps2c_p1;
      ps2d_p0 <= ps2_data;
      ps2d_p1 <= ps2d_p0;
    end
  end

  assign fall   = ps2c_p2 & ~ps2c_p1;
  assign bit_in = ps2d_p1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      tmo_cnt    <= '0;
      vld_p1     <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      vld_p1     <= 1'b0;
      parity_err <= 1'b0;
      if (state == IDLE || fall) tmo_cnt <= '0;
      else                       tmo_cnt <= tmo_cnt + TW'(1);
      if (state != IDLE && !fall && tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
        state <= IDLE;
      end else if (fall) begin
        case (state)
          IDLE: if (!bit_in) begin
            state   <= DATA;
            bit_cnt <= '0;
          end
          DATA: begin
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= PARITY;
          end
          PARITY: state <= STOP;
          STOP: begin
            vld_p1     <= frame_ok(code_p0, par_p0, bit_in);
            parity_err <= ~frame_ok(code_p0, par_p0, bit_in);
            state      <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Stage p0: shift register and parity capture; stage p1: completed code held for decode.
  always_ff @(posedge clk) begin
    if (fall) begin
      if (state == DATA)   code_p0 <= {bit_in, code_p0[7:1]};
      if (state == PARITY) par_p0  <= bit_in;
      if (state == STOP)   code_p1 <= code_p0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ext <= 1'b0;
      brk <= 1'b0;
    end else if (fall && state == STOP && !frame_ok(code_p0, par_p0, bit_in)) begin
      ext <= 1'b0;
      brk <= 1'b0;
    end else if (vld_p1) begin
      if (code_p1 == 8'hE0) begin
        ext <= 1'b1;
      end else if (code_p1 == 8'hF0) begin
        brk <= 1'b1;
      end else begin
        ext <= 1'b0;
        brk <= 1'b0;
      end
    end
  end

  // Stage p2: FIFO write; the entry becomes visible the cycle after decode.
  assign push    = vld_p1 && !is_prefix(code_p1);
  assign empty   = (count == '0);
  assign full    = (count == CW'(FIFO_DEPTH));
  assign do_pop  = rd_en && !empty;
  assign do_push = push && (!full || do_pop);
  assign rd_data = empty ? 10'd0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= {ext, brk, code_p1};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (push && !do_push) overflow <= 1'b1;
      else if (ovf_clr)     overflow <= 1'b0;
    end
  end

endmodule
